pim_chunk_loader: RTL and testbench

- Upstream feeder for the PIM array.
- Reads one MATRIX_SIZE x MATRIX_SIZE operand matrix from word-addressed memory (row-major, one WIDTH-bit element per address).
- Splits the matrix into NUM_OF_PIM_UNITS square chunks of CHUNK_SIZE x CHUNK_SIZE and streams them, chunk by chunk, over a valid/ready interface tagged with the destination unit index.
- Sits between the matrix memory and the per-unit PIM input ports.

---
 rtl/pim_chunk_loader_if.sv | 24 ++
 rtl/pim_chunk_loader.sv | 143 ++++++++++++++
 tb/tb_pim_chunk_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pim_chunk_loader_if.sv
// Memory-read port and tagged chunk stream of the PIM chunk loader.
interface pim_chunk_loader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN   = 10,
  parameter int unsigned UW    = 2
) ();
  logic             mem_rd_en;
  logic [LEN-1:0]   mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [UW-1:0]    out_unit;
  logic             out_last;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_unit, out_last,
    input  mem_rdata, out_ready
  );
  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_unit, out_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/pim_chunk_loader.sv
// Reads a square matrix from memory and streams it chunk by chunk, tagged with
// the destination PIM unit, through a 2-entry buffer.
module pim_chunk_loader #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned LEN              = 10,
  parameter int unsigned MATRIX_SIZE      = 16,
  parameter int unsigned NUM_OF_PIM_UNITS = 4,
  parameter int unsigned GRID             = 2,
  parameter int unsigned CHUNK_SIZE       = 8,
  parameter int unsigned UW               = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN-1:0]     base_addr,
  output logic               busy,
  output logic               done,
  pim_chunk_loader_if.master bus
);
  localparam int unsigned   CW    = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam int unsigned   TOTAL = MATRIX_SIZE * MATRIX_SIZE;
  localparam int unsigned   TW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] C_MAX = CW'(CHUNK_SIZE - 1);
  localparam logic [UW-1:0] U_MAX = UW'(NUM_OF_PIM_UNITS - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [LEN-1:0]   base_q;
  logic [UW-1:0]    unit_q;
  logic [CW-1:0]    row_q, col_q;
  logic             rd_all_q;
  logic [TW-1:0]    beat_q;
  logic             pend_q;
  logic [UW-1:0]    pend_unit_q;
  logic             pend_last_q;
  logic [WIDTH-1:0] fifo_data_q [2];
  logic [UW-1:0]    fifo_unit_q [2];
  logic [1:0]       fifo_last_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  logic             pop_c, last_pop_c, issue_c;
  logic [1:0]       occ_c;
  logic [31:0]      row_c, col_c;
  logic [LEN-1:0]   addr_c;

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pop_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue only while buffered plus in-flight elements stay below two after this cycle's pop.
  always_comb begin : dp_comb
    pop_c      = (count_q != 2'd0) && bus.out_ready;
    last_pop_c = pop_c && (beat_q == T_MAX);
    occ_c      = count_q + {1'b0, pend_q} - {1'b0, pop_c};
    issue_c    = (state_q == RUN) && !rd_all_q && (occ_c < 2'd2);
    row_c      = (32'(unit_q) / GRID) * CHUNK_SIZE + 32'(row_q);
    col_c      = (32'(unit_q) % GRID) * CHUNK_SIZE + 32'(col_q);
    addr_c     = base_q + LEN'(row_c * MATRIX_SIZE + col_c);
  end

  always_comb begin : out_comb
    busy          = (state_q == RUN);
    done          = (state_q == DONE);
    bus.mem_rd_en = issue_c;
    bus.mem_addr  = issue_c ? addr_c : '0;
    bus.out_valid = (count_q != 2'd0);
    bus.out_data  = fifo_data_q[rd_ptr_q];
    bus.out_unit  = fifo_unit_q[rd_ptr_q];
    bus.out_last  = fifo_last_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin : dp_reg
    if (!rst_n) begin
      base_q      <= '0;
      unit_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rd_all_q    <= 1'b0;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      pend_unit_q <= '0;
      pend_last_q <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        fifo_data_q[k] <= '0;
        fifo_unit_q[k] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        base_q   <= base_addr;
        unit_q   <= '0;
        row_q    <= '0;
        col_q    <= '0;
        rd_all_q <= 1'b0;
        beat_q   <= '0;
      end
      // Read cursor walks column, then row, then unit.
      if (issue_c) begin
        col_q <= col_q + CW'(1);
        if (col_q == C_MAX) begin
          col_q <= '0;
          row_q <= row_q + CW'(1);
          if (row_q == C_MAX) begin
            row_q  <= '0;
            unit_q <= unit_q + UW'(1);
            if (unit_q == U_MAX) rd_all_q <= 1'b1;
          end
        end
      end
      pend_q      <= issue_c;
      pend_unit_q <= unit_q;
      pend_last_q <= (row_q == C_MAX) && (col_q == C_MAX);
      if (pend_q) begin
        fifo_data_q[wr_ptr_q] <= bus.mem_rdata;
        fifo_unit_q[wr_ptr_q] <= pend_unit_q;
        fifo_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
        beat_q   <= beat_q + TW'(1);
      end
      count_q <= count_q + {1'b0, pend_q} - {1'b0, pop_c};
    end
  end
endmodule

// File: tb/tb_pim_chunk_loader.sv
// Bench for pim_chunk_loader: memory model, beat monitor and a chunk-order reference model.
module tb_pim_chunk_loader;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned LEN   = 10;
  localparam int unsigned MS    = 16;
  localparam int unsigned GRID  = 2;
  localparam int unsigned CS    = 8;
  localparam int unsigned UW    = 2;
  localparam int          TOTAL = MS * MS;
  localparam int          DEPTH = 1 << LEN;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [LEN-1:0] base_addr = '0;
  logic           busy, done;

  pim_chunk_loader_if #(.WIDTH(WIDTH), .LEN(LEN), .UW(UW)) bus ();

  pim_chunk_loader #(
    .WIDTH(WIDTH), .LEN(LEN), .MATRIX_SIZE(MS), .NUM_OF_PIM_UNITS(GRID * GRID),
    .GRID(GRID), .CHUNK_SIZE(CS), .UW(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  int total_checks = 0;
  int passed_checks = 0;
  int ready_mode = 2;

  int cyc = 0;
  int rd_cnt, done_cnt, done_cyc, first_rd_cyc, first_vld_cyc, last_beat_cyc;
  int rd_after_done_cyc, stall_err, busy_done_err, iss, xfer, max_outst;
  logic [WIDTH-1:0] bd [$];
  logic [UW-1:0]    bu [$];
  bit               bl [$];
  logic [LEN-1:0]   ra [$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic [UW-1:0]    prev_unit;
  logic             prev_last;

  // Observe the cycle half-way between edges.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_rd_en === 1'b1) begin
      rd_cnt++; iss++;
      ra.push_back(bus.mem_addr);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (done_cnt > 0 && rd_after_done_cyc < 0) rd_after_done_cyc = cyc;
    end
    if (bus.out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      bd.push_back(bus.out_data);
      bu.push_back(bus.out_unit);
      bl.push_back(bus.out_last);
      xfer++;
      last_beat_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy !== 1'b0) busy_done_err++;
    end
    if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                       bus.out_unit !== prev_unit || bus.out_last !== prev_last))
      stall_err++;
    prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
    prev_data  = bus.out_data;
    prev_unit  = bus.out_unit;
    prev_last  = bus.out_last;
    if (iss - xfer > max_outst) max_outst = iss - xfer;
  end

  task automatic clear_mon();
    bd.delete(); bu.delete(); bl.delete(); ra.delete();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; first_rd_cyc = -1; first_vld_cyc = -1;
    last_beat_cyc = -1; rd_after_done_cyc = -1; stall_err = 0; busy_done_err = 0;
    iss = 0; xfer = 0; max_outst = 0; prev_stall = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(99, 0) < 30);
      default: ;
    endcase
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int i = 0;
    while (done_cnt < n && i < budget) begin cycle(); i++; end
    ok = (done_cnt >= n);
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int i = 0;
    while (bd.size() < n && i < budget) begin cycle(); i++; end
    ok = (bd.size() >= n);
  endtask

  // Reference order: unit-major, then row-major inside each chunk.
  function automatic logic [LEN-1:0] m_addr(input logic [LEN-1:0] base, input int k);
    int u, i, j, r, c;
    u = k / (CS * CS);
    i = (k % (CS * CS)) / CS;
    j = k % CS;
    r = (u / GRID) * CS + i;
    c = (u % GRID) * CS + j;
    return LEN'((int'(base) + r * MS + c) % DEPTH);
  endfunction

  function automatic int count_seq_errs(input logic [LEN-1:0] base, input int first, input int n);
    int errs = 0;
    int idx;
    logic [LEN-1:0] a;
    for (int k = 0; k < n; k++) begin
      idx = first + k;
      a = m_addr(base, k);
      if (idx >= bd.size() || idx >= ra.size()) errs++;
      else if (bd[idx] !== mem[a] || bu[idx] !== UW'(k / (CS * CS)) ||
               bl[idx] !== ((k % (CS * CS)) == CS * CS - 1) || ra[idx] !== a) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(); cycle();
    total_checks++;
    if ({busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000",
               {busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last});
    else passed_checks++;
    total_checks++;
    if (bus.mem_addr !== '0 || bus.out_data !== '0 || bus.out_unit !== '0)
      $display("FAIL reset_buses: addr %0d data %0d unit %0d required 0",
               bus.mem_addr, bus.out_data, bus.out_unit);
    else passed_checks++;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_linear();
    bit ok;
    int e0, nl, badl;
    for (int a = 0; a < DEPTH; a++) mem[a] = WIDTH'(a);
    ready_mode = 0;
    clear_mon();
    base_addr = '0; start = 1'b1;
    cycle();
    start = 1'b0;
    e0 = cyc;
    total_checks++;
    if (busy !== 1'b1) $display("FAIL lin_busy: got %b required 1", busy); else passed_checks++;
    wait_done(1, 2000, ok);
    cycle(); cycle();
    total_checks++;
    if (!ok) $display("FAIL lin_timeout: done_cnt %0d required 1", done_cnt); else passed_checks++;
    total_checks++;
    if (bd.size() !== TOTAL) $display("FAIL lin_beats: got %0d required %0d", bd.size(), TOTAL);
    else passed_checks++;
    total_checks++;
    if (count_seq_errs('0, 0, TOTAL) !== 0)
      $display("FAIL lin_seq: got %0d bad beats required 0", count_seq_errs('0, 0, TOTAL));
    else passed_checks++;
    if (bd.size() == TOTAL) begin
      total_checks++;
      if (bd[8] !== 32'd16 || bd[64] !== 32'd8 || bd[128] !== 32'd128 || bd[192] !== 32'd136)
        $display("FAIL lin_anchors: got %0d %0d %0d %0d required 16 8 128 136",
                 bd[8], bd[64], bd[128], bd[192]);
      else passed_checks++;
    end
    nl = 0; badl = 0;
    for (int k = 0; k < bd.size(); k++) if (bl[k]) begin nl++; if (k % 64 != 63) badl++; end
    total_checks++;
    if (nl !== 4 || badl !== 0)
      $display("FAIL lin_last: got %0d lasts %0d misplaced required 4 0", nl, badl);
    else passed_checks++;
    total_checks++;
    if (done_cyc !== last_beat_cyc + 1)
      $display("FAIL lin_done_time: got cycle %0d required %0d", done_cyc, last_beat_cyc + 1);
    else passed_checks++;
    total_checks++;
    if (rd_cnt !== TOTAL) $display("FAIL lin_reads: got %0d required %0d", rd_cnt, TOTAL);
    else passed_checks++;
    total_checks++;
    if (first_rd_cyc !== e0 + 1 || first_vld_cyc !== e0 + 3)
      $display("FAIL lin_latency: rd %0d vld %0d required %0d %0d",
               first_rd_cyc, first_vld_cyc, e0 + 1, e0 + 3);
    else passed_checks++;
    total_checks++;
    if (last_beat_cyc - first_vld_cyc !== TOTAL - 1)
      $display("FAIL lin_throughput: got span %0d required %0d", last_beat_cyc - first_vld_cyc, TOTAL - 1);
    else passed_checks++;
    total_checks++;
    if (done_cnt !== 1 || busy_done_err !== 0 || busy !== 1'b0)
      $display("FAIL lin_done: got done %0d busy_err %0d busy %b required 1 0 0",
               done_cnt, busy_done_err, busy);
    else passed_checks++;
  endtask

  task automatic test_random_ready();
    bit ok;
    ready_mode = 1;
    clear_mon();
    base_addr = '0; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(1, 6000, ok);
    cycle(); cycle();
    total_checks++;
    if (!ok || bd.size() !== TOTAL) $display("FAIL rnd_beats: got %0d required %0d", bd.size(), TOTAL);
    else passed_checks++;
    total_checks++;
    if (count_seq_errs('0, 0, TOTAL) !== 0)
      $display("FAIL rnd_seq: got %0d bad beats required 0", count_seq_errs('0, 0, TOTAL));
    else passed_checks++;
    total_checks++;
    if (stall_err !== 0) $display("FAIL rnd_stable: got %0d changes required 0", stall_err);
    else passed_checks++;
    total_checks++;
    if (max_outst > 2) $display("FAIL rnd_outstanding: got %0d required <= 2", max_outst);
    else passed_checks++;
    total_checks++;
    if (done_cnt !== 1) $display("FAIL rnd_done: got %0d required 1", done_cnt); else passed_checks++;
  endtask

  task automatic test_base_wrap();
    bit ok;
    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
    ready_mode = 1;
    clear_mon();
    base_addr = LEN'(1000); start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(1, 6000, ok);
    cycle(); cycle();
    total_checks++;
    if (!ok || bd.size() !== TOTAL || ra.size() !== TOTAL)
      $display("FAIL wrap_beats: got %0d beats %0d reads required %0d", bd.size(), ra.size(), TOTAL);
    else passed_checks++;
    if (bd.size() == TOTAL && ra.size() == TOTAL) begin
      total_checks++;
      if (ra[0] !== LEN'(1000) || ra[72] !== LEN'(0) || bd[72] !== mem[0] || bu[72] !== UW'(1))
        $display("FAIL wrap_anchor: addr0 %0d addr72 %0d data72 %0h unit72 %0d required 1000 0 %0h 1",
                 ra[0], ra[72], bd[72], bu[72], mem[0]);
      else passed_checks++;
    end
    total_checks++;
    if (count_seq_errs(LEN'(1000), 0, TOTAL) !== 0)
      $display("FAIL wrap_seq: got %0d bad beats required 0", count_seq_errs(LEN'(1000), 0, TOTAL));
    else passed_checks++;
  endtask

  task automatic test_stall();
    bit ok;
    logic [LEN-1:0] b;
    b = LEN'($urandom);
    ready_mode = 2;
    bus.out_ready = 1'b0;
    clear_mon();
    base_addr = b; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 20 && first_vld_cyc < 0; n++) cycle();
    repeat (9) cycle();
    total_checks++;
    if (first_vld_cyc < 0 || rd_cnt !== 2)
      $display("FAIL stall_reads: got %0d reads valid_cycle %0d required 2", rd_cnt, first_vld_cyc);
    else passed_checks++;
    total_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== mem[b] || bus.out_unit !== '0 ||
        stall_err !== 0 || bd.size() !== 0)
      $display("FAIL stall_hold: valid %b data %0h unit %0d changes %0d required 1 %0h 0 0",
               bus.out_valid, bus.out_data, bus.out_unit, stall_err, mem[b]);
    else passed_checks++;
    ready_mode = 0;
    bus.out_ready = 1'b1;
    wait_done(1, 2000, ok);
    cycle(); cycle();
    total_checks++;
    if (!ok || bd.size() !== TOTAL || count_seq_errs(b, 0, TOTAL) !== 0)
      $display("FAIL stall_resume: got %0d beats %0d bad required %0d 0",
               bd.size(), count_seq_errs(b, 0, TOTAL), TOTAL);
    else passed_checks++;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    int d1;
    logic [LEN-1:0] b1, b2;
    b1 = LEN'($urandom);
    b2 = LEN'($urandom);
    ready_mode = 0;
    clear_mon();
    base_addr = b1; start = 1'b1;
    cycle();
    wait_beats(50, 500, ok1);
    base_addr = b2;
    wait_done(1, 2000, ok2);
    d1 = done_cyc;
    cycle();
    start = 1'b0;
    wait_done(2, 2000, ok3);
    cycle(); cycle();
    total_checks++;
    if (!(ok1 && ok2 && ok3) || done_cnt !== 2 || bd.size() !== 2 * TOTAL)
      $display("FAIL b2b_count: got %0d done %0d beats required 2 %0d", done_cnt, bd.size(), 2 * TOTAL);
    else passed_checks++;
    total_checks++;
    if (count_seq_errs(b1, 0, TOTAL) !== 0 || count_seq_errs(b2, TOTAL, TOTAL) !== 0)
      $display("FAIL b2b_seq: got %0d and %0d bad beats required 0 0",
               count_seq_errs(b1, 0, TOTAL), count_seq_errs(b2, TOTAL, TOTAL));
    else passed_checks++;
    total_checks++;
    if (rd_after_done_cyc - d1 !== 2)
      $display("FAIL b2b_restart: got %0d cycles after done required 2", rd_after_done_cyc - d1);
    else passed_checks++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n_pre;
    logic [LEN-1:0] b, b2;
    b = LEN'($urandom);
    b2 = LEN'($urandom);
    ready_mode = 0;
    clear_mon();
    base_addr = b; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_beats(100, 500, ok);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    total_checks++;
    if (!ok || {busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0 ||
        bus.mem_addr !== '0 || bus.out_data !== '0 || bus.out_unit !== '0)
      $display("FAIL midrst_outputs: flags %b addr %0d data %0h unit %0d required all 0",
               {busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last},
               bus.mem_addr, bus.out_data, bus.out_unit);
    else passed_checks++;
    n_pre = bd.size();
    repeat (5) cycle();
    total_checks++;
    if (bd.size() !== n_pre || done_cnt !== 0 || count_seq_errs(b, 0, n_pre) !== 0)
      $display("FAIL midrst_quiet: beats %0d->%0d done %0d prefix_bad %0d required no change 0 0",
               n_pre, bd.size(), done_cnt, count_seq_errs(b, 0, n_pre));
    else passed_checks++;
    clear_mon();
    base_addr = b2; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(1, 2000, ok);
    cycle(); cycle();
    total_checks++;
    if (!ok || bd.size() !== TOTAL || count_seq_errs(b2, 0, TOTAL) !== 0)
      $display("FAIL midrst_restart: got %0d beats %0d bad required %0d 0",
               bd.size(), count_seq_errs(b2, 0, TOTAL), TOTAL);
    else passed_checks++;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    clear_mon();
    test_reset();
    test_linear();
    test_random_ready();
    test_base_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
